// File: rtl/upc_scanner.sv
// Checkout scanner: accepts a UPC code on a valid/ready handshake, looks up sale/expensive
// masks, raises a latched theft alarm for unmarked expensive items, keeps saturating counters.
module upc_scanner #(
  parameter int                  UPC_W     = 3,
  parameter logic [2**UPC_W-1:0] SALE_MASK = 8'b1110_1100,
  parameter logic [2**UPC_W-1:0] EXP_MASK  = 8'b0011_0001,
  parameter int                  CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             scan_valid,
  output logic             scan_ready,
  input  logic [UPC_W-1:0] upc,
  input  logic             mark,
  input  logic             clear_alarm,
  input  logic             clear_counts,
  output logic             result_valid,
  output logic             sale,
  output logic             stolen,
  output logic             alarm,
  output logic [UPC_W-1:0] last_upc,
  output logic [CNT_W-1:0] scan_count,
  output logic [CNT_W-1:0] sale_count,
  output logic [CNT_W-1:0] stolen_count
);

  typedef enum logic [1:0] {ST_IDLE, ST_EVAL, ST_DONE, ST_ALARM} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_mark;
  logic               r_sale;
  logic               r_stolen;
  logic               r_result_valid;
  logic [UPC_W-1:0]   r_last_upc;
  logic [CNT_W-1:0]   r_scan_cnt;
  logic [CNT_W-1:0]   r_sale_cnt;
  logic [CNT_W-1:0]   r_stolen_cnt;
  logic               w_accept;
  logic               w_sale_v;
  logic               w_stolen_v;

  function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  assign w_accept   = scan_valid && (r_state == ST_IDLE);
  assign w_sale_v   = SALE_MASK[r_last_upc];
  assign w_stolen_v = EXP_MASK[r_last_upc] & ~r_mark;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_state_nxt = ST_EVAL;
      ST_EVAL:  w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = r_stolen ? ST_ALARM : ST_IDLE;
      ST_ALARM: if (clear_alarm) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Verdicts and the displayed code persist across IDLE until the next scan overwrites them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_upc     <= '0;
      r_mark         <= 1'b0;
      r_sale         <= 1'b0;
      r_stolen       <= 1'b0;
      r_result_valid <= 1'b0;
    end else begin
      r_result_valid <= (r_state == ST_EVAL);
      if (w_accept) begin
        r_last_upc <= upc;
        r_mark     <= mark;
      end
      if (r_state == ST_EVAL) begin
        r_sale   <= w_sale_v;
        r_stolen <= w_stolen_v;
      end
    end
  end

  // A clear on the same edge as an evaluation discards that evaluation's increments.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_scan_cnt   <= '0;
      r_sale_cnt   <= '0;
      r_stolen_cnt <= '0;
    end else if (clear_counts) begin
      r_scan_cnt   <= '0;
      r_sale_cnt   <= '0;
      r_stolen_cnt <= '0;
    end else if (r_state == ST_EVAL) begin
      r_scan_cnt <= f_sat_inc(r_scan_cnt);
      if (w_sale_v)   r_sale_cnt   <= f_sat_inc(r_sale_cnt);
      if (w_stolen_v) r_stolen_cnt <= f_sat_inc(r_stolen_cnt);
    end
  end

  assign scan_ready   = (r_state == ST_IDLE);
  assign alarm        = (r_state == ST_ALARM);
  assign result_valid = r_result_valid;
  assign sale         = r_sale;
  assign stolen       = r_stolen;
  assign last_upc     = r_last_upc;
  assign scan_count   = r_scan_cnt;
  assign sale_count   = r_sale_cnt;
  assign stolen_count = r_stolen_cnt;

endmodule

// File: tb/tb_upc_scanner.sv
// Bench for upc_scanner: default-parameter instance A and a UPC_W=4/CNT_W=2 instance B,
// driven one at a time; a scan-level scoreboard predicts every cycle of the selected instance.
module tb_upc_scanner;

  localparam logic [7:0]  A_SALE = 8'b1110_1100;
  localparam logic [7:0]  A_EXP  = 8'b0011_0001;
  localparam logic [15:0] B_SALE = 16'hA5C3;
  localparam logic [15:0] B_EXP  = 16'h0F18;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n, sel, sv, mark, clr_alarm, clr_counts;
  logic [3:0] upc;
  int checks = 0, failures = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       a_ready, a_rv, a_sale, a_stolen, a_alarm;
  logic [2:0] a_last;
  logic [7:0] a_scan, a_salec, a_stc;
  logic       b_ready, b_rv, b_sale, b_stolen, b_alarm;
  logic [3:0] b_last;
  logic [1:0] b_scan, b_salec, b_stc;

  upc_scanner u_a (
    .clk(clk), .reset_n(reset_n), .scan_valid(sv & ~sel), .scan_ready(a_ready),
    .upc(upc[2:0]), .mark(mark), .clear_alarm(clr_alarm & ~sel),
    .clear_counts(clr_counts & ~sel), .result_valid(a_rv), .sale(a_sale),
    .stolen(a_stolen), .alarm(a_alarm), .last_upc(a_last), .scan_count(a_scan),
    .sale_count(a_salec), .stolen_count(a_stc)
  );

  upc_scanner #(.UPC_W(4), .SALE_MASK(B_SALE), .EXP_MASK(B_EXP), .CNT_W(2)) u_b (
    .clk(clk), .reset_n(reset_n), .scan_valid(sv & sel), .scan_ready(b_ready),
    .upc(upc), .mark(mark), .clear_alarm(clr_alarm & sel),
    .clear_counts(clr_counts & sel), .result_valid(b_rv), .sale(b_sale),
    .stolen(b_stolen), .alarm(b_alarm), .last_upc(b_last), .scan_count(b_scan),
    .sale_count(b_salec), .stolen_count(b_stc)
  );

  // View of whichever instance is currently being exercised.
  logic       v_ready, v_rv, v_sale, v_stolen, v_alarm;
  logic [3:0] v_last;
  logic [7:0] v_scan, v_salec, v_stc;
  assign v_ready  = sel ? b_ready  : a_ready;
  assign v_rv     = sel ? b_rv     : a_rv;
  assign v_sale   = sel ? b_sale   : a_sale;
  assign v_stolen = sel ? b_stolen : a_stolen;
  assign v_alarm  = sel ? b_alarm  : a_alarm;
  assign v_last   = sel ? b_last   : {1'b0, a_last};
  assign v_scan   = sel ? {6'b0, b_scan}  : a_scan;
  assign v_salec  = sel ? {6'b0, b_salec} : a_salec;
  assign v_stc    = sel ? {6'b0, b_stc}   : a_stc;

  typedef struct {
    int       due;
    logic [3:0] code;
    logic     s;
    logic     t;
  } item_t;
  item_t q[$];
  int   m_scan, m_sale, m_st;
  logic exp_alarm;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Per-cycle comparison against the scoreboard.
  always @(negedge clk) begin
    if (reset_n) begin
      chk("scan_ready", int'(v_ready), int'(q.size() == 0 && !exp_alarm));
      chk("alarm", int'(v_alarm), int'(exp_alarm));
      if (q.size() > 0 && q[0].due == cyc) begin
        chk("result_valid", int'(v_rv), 1);
        chk("sale", int'(v_sale), int'(q[0].s));
        chk("stolen", int'(v_stolen), int'(q[0].t));
        chk("last_upc", int'(v_last), int'(q[0].code));
        chk("scan_count", int'(v_scan), m_scan);
        chk("sale_count", int'(v_salec), m_sale);
        chk("stolen_count", int'(v_stc), m_st);
        if (q[0].t) exp_alarm = 1'b1;
        void'(q.pop_front());
      end else begin
        chk("result_valid_quiet", int'(v_rv), 0);
      end
    end
  end

  function automatic logic f_stolen(input logic [3:0] code, input logic mk);
    return (sel ? B_EXP[code] : A_EXP[code[2:0]]) & ~mk;
  endfunction

  // Presents a code, waits for acceptance, records the prediction; returns in the result cycle.
  task automatic scan(input logic [3:0] code, input logic mk, input logic clr_on_eval);
    bit    ok = 0;
    item_t it;
    int    cmax = sel ? 3 : 255;
    upc = code; mark = mk; sv = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (v_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      chk("accept_timeout", 0, 1);
      sv = 1'b0;
      return;
    end
    @(posedge clk); #1;
    sv = 1'b0;
    it.due  = cyc + 1;
    it.code = code;
    it.s    = sel ? B_SALE[code] : A_SALE[code[2:0]];
    it.t    = f_stolen(code, mk);
    q.push_back(it);
    if (m_scan < cmax) m_scan++;
    if (it.s && m_sale < cmax) m_sale++;
    if (it.t && m_st < cmax) m_st++;
    clr_counts = clr_on_eval;
    @(posedge clk); #1;
    clr_counts = 1'b0;
    if (clr_on_eval) begin m_scan = 0; m_sale = 0; m_st = 0; end
  endtask

  task automatic ack_alarm();
    clr_alarm = 1'b1;
    @(posedge clk); #1;
    clr_alarm = 1'b0;
    exp_alarm = 1'b0;
  endtask

  initial begin
    int lit_sale[8] = '{0, 0, 1, 1, 0, 1, 1, 1};
    logic [3:0] c;
    reset_n = 1'b1; sel = 1'b0; sv = 1'b0; upc = '0; mark = 1'b0;
    clr_alarm = 1'b0; clr_counts = 1'b0; exp_alarm = 1'b0;
    m_scan = 0; m_sale = 0; m_st = 0;
    #1 reset_n = 1'b0;
    #2;
    chk("rst_ready", int'(v_ready), 1);
    chk("rst_rv", int'(v_rv), 0);
    chk("rst_sale", int'(v_sale), 0);
    chk("rst_stolen", int'(v_stolen), 0);
    chk("rst_alarm", int'(v_alarm), 0);
    chk("rst_last_upc", int'(v_last), 0);
    chk("rst_counts", int'(v_scan) + int'(v_salec) + int'(v_stc), 0);
    @(posedge clk); #1 reset_n = 1'b1;

    // All eight default codes, marked.
    for (int k = 0; k < 8; k++) begin
      scan(4'(k), 1'b1, 1'b0);
      chk("lit_sale_code", int'(a_sale), lit_sale[k]);
    end
    chk("lit_scan_count8", int'(a_scan), 8);
    chk("lit_sale_count5", int'(a_salec), 5);
    chk("lit_stolen_count0", int'(a_stc), 0);

    // Clear on the evaluation edge of an on-sale scan.
    scan(4'd2, 1'b1, 1'b1);
    chk("lit_clr_sale_count", int'(a_salec), 0);
    chk("lit_clr_scan_count", int'(a_scan), 0);
    chk("lit_clr_sale", int'(a_sale), 1);

    // Acknowledge outside ALARM must do nothing.
    @(posedge clk); #1 clr_alarm = 1'b1;
    @(posedge clk); #1 clr_alarm = 1'b0;

    // Theft: expensive code 4 without a mark; requests during ALARM are ignored.
    scan(4'd4, 1'b0, 1'b0);
    chk("lit_theft_stolen", int'(a_stolen), 1);
    chk("lit_theft_rv", int'(a_rv), 1);
    @(posedge clk); #1;
    chk("lit_alarm_on", int'(a_alarm), 1);
    chk("lit_alarm_ready", int'(a_ready), 0);
    sv = 1'b1; upc = 4'd5; mark = 1'b1;
    repeat (4) @(posedge clk);
    #1 sv = 1'b0;
    ack_alarm();
    chk("lit_ack_alarm", int'(a_alarm), 0);
    chk("lit_ack_ready", int'(a_ready), 1);
    chk("lit_ack_stolen_count", int'(a_stc), 1);
    chk("lit_hold_last_upc", int'(a_last), 4);
    chk("lit_hold_stolen", int'(a_stolen), 1);

    // Asynchronous reset while in ALARM.
    scan(4'd0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("lit_alarm2_on", int'(a_alarm), 1);
    #1 reset_n = 1'b0;
    #1;
    chk("lit_async_alarm", int'(a_alarm), 0);
    chk("lit_async_stolen", int'(a_stolen), 0);
    chk("lit_async_ready", int'(a_ready), 1);
    chk("lit_async_counts", int'(a_scan) + int'(a_salec) + int'(a_stc), 0);
    q.delete(); m_scan = 0; m_sale = 0; m_st = 0; exp_alarm = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;

    // Instance B: saturation, then all 16 codes against the custom masks.
    sel = 1'b1; m_scan = 0; m_sale = 0; m_st = 0;
    for (int k = 0; k < 5; k++) scan(4'(k), 1'b1, 1'b0);
    chk("lit_sat_scan_count", int'(b_scan), 3);
    chk("lit_b_sale_count", int'(b_salec), 2);
    for (int k = 0; k < 16; k++) begin
      c = 4'(k);
      scan(c, c[1], 1'b0);
      if (f_stolen(c, c[1])) begin
        @(posedge clk); #1;
        ack_alarm();
      end
    end
    chk("lit_b_stolen_count", int'(b_stc), 3);
    repeat (3) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
